handshake_requester: RTL and testbench

Initiator side of the team's 4-phase R/A handshake. It accepts words from a local valid/ready source, drives request R and bundled data D toward a remote responder, and steps through the full return-to-zero sequence (R↑, A↑, R↓, A↓). It flags protocol violations and responder timeouts with a sticky error, so it can sit on the same R/A wires as the team's protocol checker.

---
 rtl/handshake_requester.sv | 115 +++++++++++
 tb/tb_handshake_requester.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_requester.sv
// Initiator side of the 4-phase R/A return-to-zero handshake.
// Takes words from a local valid/ready source, drives R with bundled data D,
// and flags protocol violations or responder timeouts with a sticky E.
module handshake_requester #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             A,
  output logic             R,
  output logic [WIDTH-1:0] D,
  output logic             done,
  output logic             E,
  output logic [1:0]       state,
  output logic [7:0]       xfer_count
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        st_q;
  state_t        st_d;
  logic          a1;
  logic          a_s;
  logic [CW-1:0] wait_cnt;
  logic          capture;
  logic          complete;

  // Two-flop synchronizer for the asynchronous acknowledge
  always_ff @(posedge clk) begin
    if (RESET) begin
      a1  <= 1'b0;
      a_s <= 1'b0;
    end else begin
      a1  <= A;
      a_s <= a1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (RESET) st_q <= IDLE;
    else       st_q <= st_d;
  end

  // Next-state decode; an ack seen in IDLE outranks a pending local word
  always_comb begin
    st_d     = st_q;
    capture  = 1'b0;
    complete = 1'b0;
    in_ready = 1'b0;
    case (st_q)
      IDLE: begin
        in_ready = !a_s;
        if (a_s) begin
          st_d = ERR;
        end else if (in_valid) begin
          st_d    = REQ;
          capture = 1'b1;
        end
      end
      REQ: begin
        if (a_s)                  st_d = REL;
        else if (wait_cnt == TMO) st_d = ERR;
      end
      REL: begin
        if (!a_s) begin
          st_d     = IDLE;
          complete = 1'b1;
        end else if (wait_cnt == TMO) begin
          st_d = ERR;
        end
      end
      default: st_d = ERR;
    endcase
  end

  // Registered outputs, bundled data, transfer count and per-phase wait counter
  always_ff @(posedge clk) begin
    if (RESET) begin
      R          <= 1'b0;
      D          <= '0;
      done       <= 1'b0;
      E          <= 1'b0;
      xfer_count <= '0;
      wait_cnt   <= '0;
    end else begin
      R    <= (st_d == REQ);
      E    <= (st_d == ERR);
      done <= complete;
      if (capture)  D          <= in_data;
      if (complete) xfer_count <= xfer_count + 8'd1;
      if (st_d != st_q) begin
        wait_cnt <= '0;
      end else if ((st_q == REQ || st_q == REL) && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_handshake_requester.sv
// Scoreboard bench for handshake_requester: accepted words are queued by the
// driver, and a negedge monitor checks data and count at every R rise and done.
`timescale 1ns/1ps
module tb_handshake_requester;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 15;
  localparam int          BOUND   = 200;

  logic             clk = 1'b0;
  logic             RESET;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             A;
  logic             R;
  logic [WIDTH-1:0] D;
  logic             done;
  logic             E;
  logic [1:0]       state;
  logic [7:0]       xfer_count;

  logic             a_reg;
  logic             zero_mode;
  logic             mon_en = 1'b0;
  logic             prev_r = 1'b0;
  logic [7:0]       model_cnt;
  logic [WIDTH-1:0] mon_w;
  logic [WIDTH-1:0] exp_q[$];
  int               done_cyc[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               done_total = 0;

  // Responder model: either scripted by the stimulus or a zero-delay echo of R
  assign A = zero_mode ? R : a_reg;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  handshake_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .A          (A),
    .R          (R),
    .D          (D),
    .done       (done),
    .E          (E),
    .state      (state),
    .xfer_count (xfer_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: pops the expected word on each done and checks data and count
  always @(negedge clk) begin
    if (mon_en) begin
      if (R && !prev_r) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL r_rise_unexpected: got D=%0h expected no request", D);
        end else if (D !== exp_q[0]) begin
          failures++;
          $display("FAIL d_at_r_rise: got %0h expected %0h", D, exp_q[0]);
        end
      end
      if (done) begin
        done_total++;
        done_cyc.push_back(cyc);
        model_cnt = model_cnt + 8'd1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: got done=1 expected no completion");
        end else begin
          mon_w = exp_q.pop_front();
          check("done_data", 32'(D), 32'(mon_w));
        end
        check("done_count", 32'(xfer_count), 32'(model_cnt));
      end
    end
    prev_r = R;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    in_valid  = 1'b0;
    a_reg     = 1'b0;
    zero_mode = 1'b0;
    tick();
    RESET = 1'b0;
    exp_q.delete();
    done_cyc.delete();
    model_cnt = 8'd0;
  endtask

  task automatic wait_r(input logic v, input string name);
    int n = 0;
    while (R !== v && n < BOUND) begin
      tick();
      n++;
    end
    if (R !== v) timeout_fail(name);
  endtask

  // Offer a word and record it as expected once the DUT takes it
  task automatic send(input logic [7:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout_fail("send_accept");
    else           exp_q.push_back(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic transfer(input logic [7:0] w, input int up, input int dn);
    int n = 0;
    send(w);
    wait_r(1'b1, "wait_r_high");
    repeat (up) tick();
    a_reg = 1'b1;
    wait_r(1'b0, "wait_r_low");
    repeat (dn) tick();
    a_reg = 1'b0;
    while (state !== 2'd0 && n < BOUND) begin
      tick();
      n++;
    end
    if (state !== 2'd0) timeout_fail("wait_idle");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    RESET    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    do_reset();
    mon_en = 1'b1;

    // reset values
    check("rst_state", 32'(state), 32'd0);
    check("rst_r", 32'(R), 32'd0);
    check("rst_d", 32'(D), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_e", 32'(E), 32'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // single transfer
    base = done_total;
    send(8'hA5);
    check("single_r", 32'(R), 32'd1);
    check("single_d", 32'(D), 32'hA5);
    tick();
    a_reg = 1'b1;
    wait_r(1'b0, "single_r_low");
    tick();
    a_reg = 1'b0;
    repeat (6) tick();
    check("single_done_pulses", 32'(done_total - base), 32'd1);
    check("single_count", 32'(xfer_count), 32'd1);
    check("single_e", 32'(E), 32'd0);

    // back-to-back with a zero-delay responder
    do_reset();
    zero_mode = 1'b1;
    base = done_total;
    for (int i = 1; i <= 4; i++) send(8'(i));
    n = 0;
    while (done_cyc.size() < 4 && n < BOUND) begin
      tick();
      n++;
    end
    if (done_cyc.size() < 4) timeout_fail("b2b_dones");
    else begin
      for (int i = 1; i < 4; i++)
        check("b2b_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'd7);
    end
    tick();
    zero_mode = 1'b0;
    check("b2b_pulses", 32'(done_total - base), 32'd4);
    check("b2b_last_d", 32'(D), 32'h04);
    check("b2b_count", 32'(xfer_count), 32'd4);

    // REQ timeout: responder never answers
    do_reset();
    send(8'hC3);
    repeat (TIMEOUT) tick();
    check("tmo_still_req", 32'(state), 32'd1);
    check("tmo_r_high", 32'(R), 32'd1);
    tick();
    check("tmo_err", 32'(state), 32'd3);
    check("tmo_e", 32'(E), 32'd1);
    check("tmo_r_low", 32'(R), 32'd0);
    exp_q.delete();
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int i = 0; i < 5; i++) begin
      a_reg = 1'(i & 1);
      tick();
      check("tmo_in_ready", 32'(in_ready), 32'd0);
      check("tmo_stuck", 32'(state), 32'd3);
    end
    in_valid = 1'b0;
    a_reg    = 1'b0;
    check("tmo_d_held", 32'(D), 32'hC3);
    check("tmo_e_sticky", 32'(E), 32'd1);

    // spurious acknowledge in IDLE
    do_reset();
    transfer(8'h3C, 1, 1);
    tick();
    a_reg = 1'b1;
    tick();
    check("spur_idle1", 32'(state), 32'd0);
    tick();
    check("spur_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    check("spur_err", 32'(state), 32'd3);
    check("spur_e", 32'(E), 32'd1);
    check("spur_d", 32'(D), 32'h3C);
    in_valid = 1'b0;
    a_reg    = 1'b0;
    tick();

    // reset in the middle of a transfer
    do_reset();
    send(8'h42);
    tick();
    check("mid_in_req", 32'(state), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_q.delete();
    model_cnt = 8'd0;
    check("mid_r", 32'(R), 32'd0);
    check("mid_state", 32'(state), 32'd0);
    check("mid_e", 32'(E), 32'd0);
    check("mid_count", 32'(xfer_count), 32'd0);
    base = done_total;
    transfer(8'h5A, 1, 2);
    tick();
    check("mid_after_count", 32'(xfer_count), 32'd1);
    check("mid_after_pulses", 32'(done_total - base), 32'd1);
    check("mid_after_e", 32'(E), 32'd0);

    // counter wrap over 256 randomized transfers
    do_reset();
    base = done_total;
    for (int i = 0; i < 256; i++)
      transfer(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    tick();
    check("wrap_pulses", 32'(done_total - base), 32'd256);
    check("wrap_count", 32'(xfer_count), 32'd0);
    check("wrap_e", 32'(E), 32'd0);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
